// File: rtl/memory_cycle_pkg.sv
// mem_stage_pkg: handshake state encoding and width defaults for the memory stage
package mem_stage_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RADDR_W_DEF = 5;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
endpackage

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: M-stage inputs, data-memory handshake and W-stage outputs
// MEM_MISALIGN_TRAP_EN adds the MisalignW signal.
interface memory_cycle_if import mem_stage_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
);
  logic RegWriteM, MemWriteM, ResultSrcM;
  logic [RADDR_W-1:0] RD_M;
  logic [DATA_W-1:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic DMemReq, DMemWe, DMemGnt, DMemRValid;
  logic [DATA_W-1:0] DMemAddr, DMemWData, DMemRData;
  logic StallM;
  logic RegWriteW, ResultSrcW;
  logic [RADDR_W-1:0] RD_W;
  logic [DATA_W-1:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MEM_MISALIGN_TRAP_EN
  logic MisalignW;
`endif
  modport slave (
`ifdef MEM_MISALIGN_TRAP_EN
    output MisalignW,
`endif
    input RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
    input DMemGnt, DMemRValid, DMemRData,
    output DMemReq, DMemWe, DMemAddr, DMemWData, StallM,
    output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
  );
  modport master (
`ifdef MEM_MISALIGN_TRAP_EN
    input MisalignW,
`endif
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
    output DMemGnt, DMemRValid, DMemRData,
    input DMemReq, DMemWe, DMemAddr, DMemWData, StallM,
    input RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
  );
endinterface

// File: rtl/memory_cycle_dmem_if_fsm.sv
// dmem_if_fsm: data-memory request/grant/response handshake, producing request, completion and stall
module dmem_if_fsm import mem_stage_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic mem_write_i,
  input  logic result_src_i,
  input  logic misalign_i,
  input  logic gnt_i,
  input  logic rvalid_i,
  output logic dmem_req_o,
  output logic complete_o,
  output logic stall_m_o
);
  state_t state_q, state_d;
  logic op, access;
  always_comb begin
    op = mem_write_i | result_src_i;
    access = op & !misalign_i;
    dmem_req_o = rst & (((state_q == IDLE) & access) | (state_q == REQ));
    complete_o = !op | misalign_i | (mem_write_i & gnt_i & dmem_req_o) | ((state_q == RESP) & rvalid_i);
    stall_m_o = rst & op & !complete_o;
    state_d = dmem_req_o ? (!gnt_i ? REQ : mem_write_i ? IDLE : RESP)
            : ((state_q == RESP) & rvalid_i) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: memory pipeline stage with data-memory handshake and MEM/WB register
// MEM_MISALIGN_TRAP_EN turns misaligned accesses into a one-cycle MisalignW trap.
module memory_cycle import mem_stage_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input logic clk,
  input logic rst,
  memory_cycle_if.slave bus
);
  logic complete, stall, mis, load;
  logic reg_write_q, reg_write_d, result_src_q, result_src_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] pc4_q, pc4_d, alu_q, alu_d, rdata_q, rdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign mis = (bus.MemWriteM | bus.ResultSrcM) & (|bus.ALU_ResultM[1:0]);
  assign bus.MisalignW = misalign_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) misalign_q <= 1'b0;
    else misalign_q <= complete & mis;
`else
  assign mis = 1'b0;
`endif
  dmem_if_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_write_i  (bus.MemWriteM),
    .result_src_i (bus.ResultSrcM),
    .misalign_i   (mis),
    .gnt_i        (bus.DMemGnt),
    .rvalid_i     (bus.DMemRValid),
    .dmem_req_o   (bus.DMemReq),
    .complete_o   (complete),
    .stall_m_o    (stall)
  );
  assign bus.StallM = stall;
  assign bus.DMemWe = bus.DMemReq & bus.MemWriteM;
  assign bus.DMemAddr = {bus.ALU_ResultM[DATA_W-1:2], 2'b00};
  assign bus.DMemWData = bus.WriteDataM;
  assign load = bus.ResultSrcM & !bus.MemWriteM & !mis;
  // an incomplete op leaves a bubble in W; data fields keep their last values
  always_comb begin
    reg_write_d = complete & bus.RegWriteM & !mis;
    result_src_d = complete & bus.ResultSrcM;
    rd_d = complete ? bus.RD_M : '0;
    pc4_d = complete ? bus.PCPlus4M : pc4_q;
    alu_d = complete ? bus.ALU_ResultM : alu_q;
    rdata_d = (complete & load) ? bus.DMemRData : rdata_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      reg_write_q <= 1'b0;
      result_src_q <= 1'b0;
      rd_q <= '0;
      pc4_q <= '0;
      alu_q <= '0;
      rdata_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q <= rd_d;
      pc4_q <= pc4_d;
      alu_q <= alu_d;
      rdata_q <= rdata_d;
    end
  assign bus.RegWriteW = reg_write_q;
  assign bus.ResultSrcW = result_src_q;
  assign bus.RD_W = rd_q;
  assign bus.PCPlus4W = pc4_q;
  assign bus.ALU_ResultW = alu_q;
  assign bus.ReadDataW = rdata_q;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed table and handshake sequences for memory_cycle
module tb_memory_cycle;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int stall_cnt;
  logic [31:0] exp_rdata;
  always #5 clk = ~clk;
  memory_cycle_if #(.DATA_W(32), .RADDR_W(5)) bus ();
  memory_cycle #(.DATA_W(32), .RADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic rw, mw, rs;
    logic [4:0] rd;
    logic [31:0] pc4, wd, alu;
    logic gnt, rv;
    logic [31:0] rdata;
    logic e_req, e_we;
    logic [31:0] e_addr;
    logic e_rw, e_rs;
    logic [4:0] e_rd;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_m(input logic rw, mw, rs, input logic [4:0] rd, input logic [31:0] pc4, wd, alu);
    bus.RegWriteM = rw;
    bus.MemWriteM = mw;
    bus.ResultSrcM = rs;
    bus.RD_M = rd;
    bus.PCPlus4M = pc4;
    bus.WriteDataM = wd;
    bus.ALU_ResultM = alu;
  endtask
  task automatic chk_w(input string nm, input logic rw, rs, input logic [4:0] rd, input logic [31:0] pc4, alu, rdata);
    chk({nm, "_RegWriteW"}, bus.RegWriteW, rw);
    chk({nm, "_ResultSrcW"}, bus.ResultSrcW, rs);
    chk({nm, "_RD_W"}, bus.RD_W, rd);
    chk({nm, "_PCPlus4W"}, bus.PCPlus4W, pc4);
    chk({nm, "_ALU_ResultW"}, bus.ALU_ResultW, alu);
    chk({nm, "_ReadDataW"}, bus.ReadDataW, rdata);
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5, 32'h104, 32'h0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 5'd5};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h108, 32'hDEADBEEF, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 5'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 5'd31, 32'h200, 32'h0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0, 5'd31};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h20C, 32'h0, 32'h24, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h24, 1'b0, 1'b0, 5'd7};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd3, 32'h210, 32'h0, 32'h1000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 5'd3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 5'd9, 32'h214, 32'h0, 32'h55, 1'b1, 1'b1, 32'hBADBAD, 1'b0, 1'b0, 32'h54, 1'b1, 1'b0, 5'd9};
    exp_rdata = 32'h0;
    set_m(1'b1, 1'b0, 1'b1, 5'd6, 32'h44, 32'h0, 32'h80);
    bus.DMemGnt = 1'b0;
    bus.DMemRValid = 1'b0;
    bus.DMemRData = 32'h0;
    #2;
    chk("rst_DMemReq", bus.DMemReq, 1'b0);
    chk("rst_StallM", bus.StallM, 1'b0);
    chk_w("rst", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_m(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].pc4, vecs[i].wd, vecs[i].alu);
      bus.DMemGnt = vecs[i].gnt;
      bus.DMemRValid = vecs[i].rv;
      bus.DMemRData = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_DMemReq", i), bus.DMemReq, vecs[i].e_req);
      chk($sformatf("v%0d_DMemWe", i), bus.DMemWe, vecs[i].e_we);
      chk($sformatf("v%0d_DMemAddr", i), bus.DMemAddr, vecs[i].e_addr);
      chk($sformatf("v%0d_StallM", i), bus.StallM, 1'b0);
      if (vecs[i].e_req) chk($sformatf("v%0d_DMemWData", i), bus.DMemWData, vecs[i].wd);
      @(posedge clk);
      #1;
      chk_w($sformatf("v%0d", i), vecs[i].e_rw, vecs[i].e_rs, vecs[i].e_rd, vecs[i].pc4, vecs[i].alu, exp_rdata);
    end
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd10, 32'h300, 32'h0, 32'h80);
    bus.DMemGnt = 1'b0;
    bus.DMemRValid = 1'b0;
    bus.DMemRData = 32'h0;
    stall_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.DMemGnt = 1'b1;
      #1;
      chk($sformatf("ld_c%0d_DMemReq", c), bus.DMemReq, 1'b1);
      chk($sformatf("ld_c%0d_DMemWe", c), bus.DMemWe, 1'b0);
      if (bus.StallM) stall_cnt++;
      @(posedge clk);
      #1;
      chk($sformatf("ld_c%0d_bubble_rw", c), bus.RegWriteW, 1'b0);
      chk($sformatf("ld_c%0d_bubble_rd", c), bus.RD_W, 5'd0);
      chk($sformatf("ld_c%0d_hold_alu", c), bus.ALU_ResultW, 32'h55);
      @(negedge clk);
    end
    bus.DMemGnt = 1'b0;
    bus.DMemRValid = 1'b1;
    bus.DMemRData = 32'h1234;
    #1;
    chk("ld_resp_DMemReq", bus.DMemReq, 1'b0);
    if (bus.StallM) stall_cnt++;
    chk("ld_stall_cycles", stall_cnt, 3);
    exp_rdata = 32'h1234;
    @(posedge clk);
    #1;
    chk_w("ld_done", 1'b1, 1'b1, 5'd10, 32'h300, 32'h80, exp_rdata);
    @(negedge clk);
    set_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h400, 32'hCAFEF00D, 32'h60);
    bus.DMemGnt = 1'b0;
    bus.DMemRValid = 1'b0;
    #1;
    chk("st_wait_DMemReq", bus.DMemReq, 1'b1);
    chk("st_wait_DMemWe", bus.DMemWe, 1'b1);
    chk("st_wait_StallM", bus.StallM, 1'b1);
    chk("st_wait_DMemWData", bus.DMemWData, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    chk("st_wait_bubble_rw", bus.RegWriteW, 1'b0);
    chk("st_wait_hold_alu", bus.ALU_ResultW, 32'h80);
    @(negedge clk);
    bus.DMemGnt = 1'b1;
    #1;
    chk("st_gnt_DMemReq", bus.DMemReq, 1'b1);
    chk("st_gnt_StallM", bus.StallM, 1'b0);
    @(posedge clk);
    #1;
    chk_w("st_done", 1'b0, 1'b0, 5'd0, 32'h400, 32'h60, exp_rdata);
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd4, 32'h500, 32'h0, 32'h42);
    bus.DMemGnt = 1'b1;
    bus.DMemRValid = 1'b1;
    bus.DMemRData = 32'h77;
    #1;
    chk("mis_DMemReq", bus.DMemReq, 1'b0);
    chk("mis_StallM", bus.StallM, 1'b0);
    @(posedge clk);
    #1;
    chk("mis_MisalignW", bus.MisalignW, 1'b1);
    chk("mis_RegWriteW", bus.RegWriteW, 1'b0);
    chk("mis_ReadDataW", bus.ReadDataW, exp_rdata);
    @(negedge clk);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h8);
    bus.DMemGnt = 1'b0;
    bus.DMemRValid = 1'b0;
    @(posedge clk);
    #1;
    chk("mis_clear_MisalignW", bus.MisalignW, 1'b0);
`else
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd4, 32'h500, 32'h0, 32'h42);
    bus.DMemGnt = 1'b1;
    bus.DMemRValid = 1'b0;
    #1;
    chk("unal_DMemAddr", bus.DMemAddr, 32'h40);
    chk("unal_DMemReq", bus.DMemReq, 1'b1);
    chk("unal_StallM", bus.StallM, 1'b1);
    @(posedge clk);
    #1;
    chk("unal_bubble_rw", bus.RegWriteW, 1'b0);
    @(negedge clk);
    bus.DMemGnt = 1'b0;
    bus.DMemRValid = 1'b1;
    bus.DMemRData = 32'h77;
    #1;
    chk("unal_resp_StallM", bus.StallM, 1'b0);
    exp_rdata = 32'h77;
    @(posedge clk);
    #1;
    chk_w("unal_done", 1'b1, 1'b1, 5'd4, 32'h500, 32'h42, exp_rdata);
`endif
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd12, 32'h600, 32'h0, 32'h90);
    bus.DMemGnt = 1'b1;
    bus.DMemRValid = 1'b0;
    #1;
    chk("rr_DMemReq", bus.DMemReq, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.DMemGnt = 1'b0;
    #1;
    chk("rr_resp_DMemReq", bus.DMemReq, 1'b0);
    chk("rr_resp_StallM", bus.StallM, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("rr_rst_DMemReq", bus.DMemReq, 1'b0);
    chk("rr_rst_StallM", bus.StallM, 1'b0);
    chk_w("rr_rst", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    bus.DMemRValid = 1'b1;
    bus.DMemRData = 32'hBAD;
    rst = 1'b1;
    #1;
    chk("rr_rel_DMemReq", bus.DMemReq, 1'b0);
    chk("rr_rel_StallM", bus.StallM, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk_w($sformatf("rr_stray%0d", c), 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
